// File: rtl/dmi_host_bridge.sv
// Host-side front end for the debug module DMI port: turns a level host command
// into a single valid/ready DMI request, waits for the response and holds the result.
module dmi_host_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        host_req_i,
    input  logic        host_wr_i,
    input  logic [6:0]  host_addr_i,
    input  logic [31:0] host_wdata_i,
    output logic [31:0] host_rdata_o,
    output logic        host_ack_o,
    output logic        host_busy_o,
    output logic        host_err_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [1:0]  dmi_req_op_o,
    output logic [6:0]  dmi_req_addr_o,
    output logic [31:0] dmi_req_data_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [31:0] dmi_resp_data_i,
    input  logic [1:0]  dmi_resp_resp_i
);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            op_q;
    logic [6:0]            addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic                  ack_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  start;
    logic                  finish;
    logic                  abort;
    logic                  timeout_hit;
    logic                  in_req;
    logic                  busy;

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);
    assign in_req      = (state_q == REQ);
    assign busy        = (state_q == REQ) || (state_q == RESP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A completed handshake always takes priority over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_req_i) begin
                    start   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dmi_req_ready_i) begin
                    state_d = RESP;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            RESP: begin
                if (dmi_resp_valid_i) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!host_req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q    <= OP_NOP;
            addr_q  <= 7'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ack_q <= finish | abort;
            if (start) begin
                op_q    <= host_wr_i ? OP_WRITE : OP_READ;
                addr_q  <= host_addr_i;
                wdata_q <= host_wdata_i;
                err_q   <= 1'b0;
                cnt_q   <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (finish) begin
                if (dmi_resp_resp_i != 2'b00) begin
                    err_q <= 1'b1;
                end else if (op_q == OP_READ) begin
                    rdata_q <= dmi_resp_data_i;
                end
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    // Responses are accepted outside REQ so stale answers to aborted requests drain away.
    assign dmi_resp_ready_o = !rst_i && (state_q != REQ);
    assign dmi_req_valid_o  = in_req;
    assign dmi_req_op_o     = in_req ? op_q : OP_NOP;
    assign dmi_req_addr_o   = in_req ? addr_q : 7'd0;
    assign dmi_req_data_o   = in_req ? wdata_q : 32'd0;
    assign host_rdata_o     = rdata_q;
    assign host_ack_o       = ack_q;
    assign host_busy_o      = busy;
    assign host_err_o       = err_q;

endmodule

// File: tb/tb_dmi_host_bridge.sv
// Self-checking bench for dmi_host_bridge: vector table plus hand-written corner sequences,
// with a reactive DMI slave model and a scoreboard of expected host results.
module tb_dmi_host_bridge;

    logic        clk;
    logic        rst;
    logic        host_req;
    logic        host_wr;
    logic [6:0]  host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic        host_busy;
    logic        host_err;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [1:0]  dmi_req_op;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_resp;

    dmi_host_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .host_req_i       (host_req),
        .host_wr_i        (host_wr),
        .host_addr_i      (host_addr),
        .host_wdata_i     (host_wdata),
        .host_rdata_o     (host_rdata),
        .host_ack_o       (host_ack),
        .host_busy_o      (host_busy),
        .host_err_o       (host_err),
        .dmi_req_valid_o  (dmi_req_valid),
        .dmi_req_ready_i  (dmi_req_ready),
        .dmi_req_op_o     (dmi_req_op),
        .dmi_req_addr_o   (dmi_req_addr),
        .dmi_req_data_o   (dmi_req_data),
        .dmi_resp_valid_i (dmi_resp_valid),
        .dmi_resp_ready_o (dmi_resp_ready),
        .dmi_resp_data_i  (dmi_resp_data),
        .dmi_resp_resp_i  (dmi_resp_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        int          ready_delay;
        logic [1:0]  resp_code;
        logic [31:0] resp_data;
        logic [1:0]  exp_op;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[7];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_count = 0;
    int ack_count = 0;
    int valid_cycles = 0;
    int ack_cyc = 0;
    int req_cyc = 0;
    int hs0 = 0;
    int ack0 = 0;

    int          cfg_ready_delay = 0;
    logic [1:0]  cfg_resp_code = 2'd0;
    logic [31:0] cfg_resp_data = 32'd0;
    logic        cfg_mute = 1'b0;
    logic        cfg_hold_resp = 1'b0;
    logic [1:0]  exp_op = 2'd0;
    logic [6:0]  exp_addr = 7'd0;
    logic [31:0] exp_data = 32'd0;

    int   wait_cnt = 0;
    logic pend = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_resp_valid = 1'b0;
    logic prev_resp_ready = 1'b0;
    logic prev_ack = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp_v);
        end
    endtask

    // Observes the settled pre-edge values of a cycle: request fields, handshakes, acks.
    task automatic monitorSample();
        sb_t e;
        if (dmi_req_valid) begin
            valid_cycles++;
            checkOutput("req_op", 32'(dmi_req_op), 32'(exp_op));
            checkOutput("req_addr", 32'(dmi_req_addr), 32'(exp_addr));
            checkOutput("req_data", dmi_req_data, exp_data);
            checkOutput("busy_in_req", 32'(host_busy), 32'd1);
            if (dmi_req_ready) hs_count++;
        end
        if (host_ack) begin
            ack_count++;
            ack_cyc = cyc;
            checkOutput("ack_pulse", 32'(prev_ack), 32'd0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_err", 32'(host_err), 32'(e.err));
                checkOutput("sb_rdata", host_rdata, e.rdata);
            end
        end
        prev_ack = host_ack;
    endtask

    task automatic slaveStep();
        if (prev_valid && prev_ready) pend = 1'b1;
        if (!cfg_mute) begin
            if (prev_resp_valid && prev_resp_ready) dmi_resp_valid = 1'b0;
            if (dmi_req_valid) begin
                if (wait_cnt >= cfg_ready_delay) begin
                    dmi_req_ready = 1'b1;
                end else begin
                    dmi_req_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                dmi_req_ready = 1'b0;
                wait_cnt = 0;
            end
            if (pend && !cfg_hold_resp) begin
                dmi_resp_valid = 1'b1;
                dmi_resp_data  = cfg_resp_data;
                dmi_resp_resp  = cfg_resp_code;
                pend = 1'b0;
            end
        end else begin
            dmi_req_ready = 1'b0;
        end
        prev_valid      = dmi_req_valid;
        prev_ready      = dmi_req_ready;
        prev_resp_valid = dmi_resp_valid;
        prev_resp_ready = dmi_resp_ready;
    endtask

    task automatic slaveReset();
        pend = 1'b0;
        wait_cnt = 0;
        dmi_req_ready = 1'b0;
        dmi_resp_valid = 1'b0;
        prev_resp_valid = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        monitorSample();
        @(posedge clk);
        cyc++;
        #1;
        slaveStep();
    endtask

    task automatic waitAck(input int base, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            if (ack_count != base) break;
            tick();
        end
        checkOutput(name, 32'(ack_count != base), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        cfg_ready_delay = v.ready_delay;
        cfg_resp_code   = v.resp_code;
        cfg_resp_data   = v.resp_data;
        exp_op   = v.exp_op;
        exp_addr = v.addr;
        exp_data = v.wdata;
        sb.push_back('{v.exp_err, v.exp_rdata});
        hs0 = hs_count;
        ack0 = ack_count;
        valid_cycles = 0;
        host_wr    = v.wr;
        host_addr  = v.addr;
        host_wdata = v.wdata;
        host_req   = 1'b1;
        req_cyc    = cyc;
        waitAck(ack0, 100, "vec_ack_seen");
        host_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b0, 7'h11, 32'h0000_0000, 0, 2'd0, 32'hDEAD_BEEF, 2'd1, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 7'h10, 32'h0000_0001, 5, 2'd0, 32'hAAAA_5555, 2'd2, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 7'h04, 32'h0000_0000, 1, 2'd3, 32'h1234_5678, 2'd1, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 7'h05, 32'h0000_0000, 0, 2'd0, 32'hCAFE_F00D, 2'd1, 1'b0, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 7'h20, 32'h5A5A_0001, 2, 2'd2, 32'h0000_0000, 2'd2, 1'b1, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 7'h7F, 32'h0000_0000, 6, 2'd0, 32'h0123_4567, 2'd1, 1'b0, 32'h0123_4567};
        vecs[6] = '{1'b0, 7'h01, 32'h0000_0000, 7, 2'd0, 32'h89AB_CDEF, 2'd1, 1'b0, 32'h89AB_CDEF};

        rst = 1'b1;
        host_req = 1'b0;
        host_wr = 1'b0;
        host_addr = 7'd0;
        host_wdata = 32'd0;
        dmi_req_ready = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp_data = 32'd0;
        dmi_resp_resp = 2'd0;
        tick();
        tick();
        tick();
        checkOutput("rst_rdata", host_rdata, 32'd0);
        checkOutput("rst_ack", 32'(host_ack), 32'd0);
        checkOutput("rst_busy", 32'(host_busy), 32'd0);
        checkOutput("rst_err", 32'(host_err), 32'd0);
        checkOutput("rst_valid", 32'(dmi_req_valid), 32'd0);
        checkOutput("rst_op", 32'(dmi_req_op), 32'd0);
        checkOutput("rst_resp_ready", 32'(dmi_resp_ready), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle_resp_ready", 32'(dmi_resp_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput("vec_req_count", 32'(hs_count - hs0), 32'd1);
            checkOutput("vec_valid_cycles", 32'(valid_cycles), 32'(vecs[i].ready_delay + 1));
            checkOutput("vec_err", 32'(host_err), 32'(vecs[i].exp_err));
            checkOutput("vec_rdata", host_rdata, vecs[i].exp_rdata);
            checkOutput("vec_busy_after", 32'(host_busy), 32'd0);
            checkOutput("vec_op_after", 32'(dmi_req_op), 32'd0);
            if (i == 0) checkOutput("min_latency", 32'(ack_cyc - req_cyc), 32'd3);
        end

        // Timeout with ready never asserted, then a late response arriving in IDLE.
        cfg_mute = 1'b1;
        slaveReset();
        exp_op = 2'd1;
        exp_addr = 7'h33;
        exp_data = 32'd0;
        sb.push_back('{1'b1, 32'h89AB_CDEF});
        hs0 = hs_count;
        ack0 = ack_count;
        valid_cycles = 0;
        host_wr = 1'b0;
        host_addr = 7'h33;
        host_wdata = 32'd0;
        host_req = 1'b1;
        waitAck(ack0, 40, "timeout_ack_seen");
        host_req = 1'b0;
        tick();
        tick();
        checkOutput("timeout_valid_cycles", 32'(valid_cycles), 32'd8);
        checkOutput("timeout_no_hs", 32'(hs_count - hs0), 32'd0);
        checkOutput("timeout_err", 32'(host_err), 32'd1);
        checkOutput("timeout_valid_dropped", 32'(dmi_req_valid), 32'd0);
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'hFFFF_FFFF;
        dmi_resp_resp  = 2'd0;
        checkOutput("drain_ready", 32'(dmi_resp_ready), 32'd1);
        tick();
        dmi_resp_valid = 1'b0;
        tick();
        tick();
        checkOutput("drain_no_ack", 32'(ack_count - ack0), 32'd1);
        checkOutput("drain_rdata", host_rdata, 32'h89AB_CDEF);
        checkOutput("drain_err", 32'(host_err), 32'd1);
        cfg_mute = 1'b0;
        slaveReset();

        // Holding the host request high must not retrigger.
        cfg_ready_delay = 0;
        cfg_resp_code = 2'd0;
        cfg_resp_data = 32'h0BAD_CAFE;
        exp_op = 2'd1;
        exp_addr = 7'h12;
        exp_data = 32'd0;
        sb.push_back('{1'b0, 32'h0BAD_CAFE});
        hs0 = hs_count;
        ack0 = ack_count;
        host_addr = 7'h12;
        host_req = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        checkOutput("hold_one_req", 32'(hs_count - hs0), 32'd1);
        checkOutput("hold_one_ack", 32'(ack_count - ack0), 32'd1);
        checkOutput("hold_rdata", host_rdata, 32'h0BAD_CAFE);
        host_req = 1'b0;
        tick();
        tick();
        cfg_resp_data = 32'h1357_2468;
        sb.push_back('{1'b0, 32'h1357_2468});
        host_req = 1'b1;
        waitAck(ack0 + 1, 50, "reassert_ack_seen");
        host_req = 1'b0;
        tick();
        tick();
        checkOutput("reassert_req", 32'(hs_count - hs0), 32'd2);
        checkOutput("reassert_rdata", host_rdata, 32'h1357_2468);

        // Reset while waiting in RESP drops the transaction.
        cfg_hold_resp = 1'b1;
        exp_addr = 7'h22;
        host_addr = 7'h22;
        host_req = 1'b1;
        ack0 = ack_count;
        for (int i = 0; i < 20; i++) begin
            if (host_busy && dmi_resp_ready) break;
            tick();
        end
        checkOutput("reached_resp", 32'(host_busy && dmi_resp_ready), 32'd1);
        rst = 1'b1;
        host_req = 1'b0;
        tick();
        checkOutput("midrst_rdata", host_rdata, 32'd0);
        checkOutput("midrst_busy", 32'(host_busy), 32'd0);
        checkOutput("midrst_ack", 32'(host_ack), 32'd0);
        checkOutput("midrst_resp_ready", 32'(dmi_resp_ready), 32'd0);
        checkOutput("midrst_valid", 32'(dmi_req_valid), 32'd0);
        rst = 1'b0;
        cfg_hold_resp = 1'b0;
        slaveReset();
        tick();
        checkOutput("midrst_no_ack", 32'(ack_count - ack0), 32'd0);
        applyStimulus('{1'b0, 7'h08, 32'h0000_0000, 1, 2'd0, 32'h600D_F00D, 2'd1, 1'b0, 32'h600D_F00D});
        checkOutput("post_rst_rdata", host_rdata, 32'h600D_F00D);
        checkOutput("post_rst_err", 32'(host_err), 32'd0);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
